// File: rtl/ysyx_20020207_axi_sram_slave_pkg.sv
// Shared AXI definitions for the SRAM responder: response and burst codes,
// FSM state encodings and the per-beat address/response helpers.
package ysyx_20020207_axi_sram_slave_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_e;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} rd_state_e;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_e;

  // WRAP bursts are deliberately walked like INCR bursts.
  function automatic logic [31:0] beat_advance(input logic [31:0] addr,
                                               input logic [2:0]  size,
                                               input logic [1:0]  burst);
    logic [31:0] nxt;
    case (burst)
      BURST_FIXED:            nxt = addr;
      BURST_INCR, BURST_WRAP: nxt = addr + (32'd1 << size);
      default:                nxt = addr + (32'd1 << size);
    endcase
    return nxt;
  endfunction

  function automatic resp_e beat_resp(input logic [31:0] addr,
                                      input logic [31:0] base,
                                      input logic [31:0] span,
                                      input logic [2:0]  size);
    if (addr < base || (addr - base) >= span) return RESP_DECERR;
    if (size > 3'd2) return RESP_SLVERR;
    return RESP_OKAY;
  endfunction

  // Encodings are ordered so the numerically larger code wins: DECERR > SLVERR > OKAY.
  function automatic resp_e resp_merge(input resp_e a, input resp_e b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ysyx_20020207_axi_sram_slave_sram_array.sv
// DEPTH_WORDS x 32 storage: one combinational read port and one clocked
// write port with per-byte enables. Contents are never reset.
module ysyx_20020207_sram_array #(
  parameter int DEPTH_WORDS = 4096
) (
  input  logic                           clk,
  input  logic [$clog2(DEPTH_WORDS)-1:0] rd_index,
  output logic [31:0]                    rd_data,
  input  logic                           wr_en,
  input  logic [$clog2(DEPTH_WORDS)-1:0] wr_index,
  input  logic [3:0]                     wr_be,
  input  logic [31:0]                    wr_data
);

  logic [31:0] mem [DEPTH_WORDS];

  assign rd_data = mem[rd_index];

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (wr_en && wr_be[b]) mem[wr_index][8*b +: 8] <= wr_data[8*b +: 8];
    end
  end

endmodule

// File: rtl/ysyx_20020207_axi_sram_slave.sv
// AXI4 responder backed by an on-chip SRAM: independent read and write FSMs,
// INCR/FIXED bursts, byte strobes, programmable read latency and DECERR decode.
module ysyx_20020207_axi_sram_slave
  import ysyx_20020207_axi_sram_slave_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
  parameter int          DEPTH_WORDS = 4096,
  parameter int          RD_LAT      = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] awaddr,
  input  logic [3:0]  awid,
  input  logic [7:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic        wvalid,
  output logic        wready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  output logic        bvalid,
  input  logic        bready,
  output logic [1:0]  bresp,
  output logic [3:0]  bid,
  input  logic        arvalid,
  output logic        arready,
  input  logic [31:0] araddr,
  input  logic [3:0]  arid,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  output logic        rvalid,
  input  logic        rready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic [3:0]  rid
);

  localparam int          AW       = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN     = 32'(4 * DEPTH_WORDS);
  localparam logic [3:0]  LAT_LAST = 4'(RD_LAT - 1);

  rd_state_e   r_state, r_state_n;
  logic [31:0] r_addr, r_addr_n;
  logic [7:0]  r_len, r_len_n, r_beat, r_beat_n;
  logic [2:0]  r_size, r_size_n;
  logic [1:0]  r_burst, r_burst_n;
  logic [3:0]  r_id, r_id_n, r_cnt, r_cnt_n;
  logic [31:0] rdata_n;
  logic [1:0]  rresp_n;
  logic        rlast_n, r_capture;
  logic [31:0] fetch_addr, fetch_data, rd_word;
  logic [2:0]  fetch_size;
  resp_e       fetch_resp;

  wr_state_e   w_state, w_state_n;
  logic [31:0] w_addr, w_addr_n;
  logic [7:0]  w_len, w_len_n, w_beat, w_beat_n;
  logic [2:0]  w_size, w_size_n;
  logic [1:0]  w_burst, w_burst_n;
  logic [3:0]  w_id, w_id_n;
  resp_e       w_resp, w_resp_n, w_beat_resp, w_merged;
  logic        wr_en;

  ysyx_20020207_sram_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
    .clk      (clk),
    .rd_index (AW'((fetch_addr - ADDR_BASE) >> 2)),
    .rd_data  (rd_word),
    .wr_en    (wr_en),
    .wr_index (AW'((w_addr - ADDR_BASE) >> 2)),
    .wr_be    (wstrb),
    .wr_data  (wdata)
  );

  assign arready = (r_state == R_IDLE);
  assign rvalid  = (r_state == R_DATA);
  assign rid     = r_id;
  assign awready = (w_state == W_IDLE);
  assign wready  = (w_state == W_DATA);
  assign bvalid  = (w_state == W_RESP);
  assign bresp   = w_resp;
  assign bid     = w_id;

  // The word to present next is fetched combinationally and captured into the
  // R outputs, so a write landing on the same edge is seen as old data.
  always_comb begin
    fetch_addr = r_addr;
    fetch_size = r_size;
    case (r_state)
      R_IDLE:  begin fetch_addr = araddr; fetch_size = arsize; end
      R_DATA:  fetch_addr = beat_advance(r_addr, r_size, r_burst);
      default: ;
    endcase
    fetch_resp = beat_resp(fetch_addr, ADDR_BASE, SPAN, fetch_size);
    fetch_data = (fetch_resp == RESP_DECERR) ? 32'd0 : rd_word;
  end

  always_comb begin
    r_state_n = r_state;
    r_addr_n  = r_addr;
    r_len_n   = r_len;
    r_size_n  = r_size;
    r_burst_n = r_burst;
    r_id_n    = r_id;
    r_beat_n  = r_beat;
    r_cnt_n   = r_cnt;
    rdata_n   = rdata;
    rresp_n   = rresp;
    rlast_n   = rlast;
    r_capture = 1'b0;
    unique case (r_state)
      R_IDLE: if (arvalid) begin
        r_addr_n  = araddr;
        r_len_n   = arlen;
        r_size_n  = arsize;
        r_burst_n = arburst;
        r_id_n    = arid;
        r_beat_n  = 8'd0;
        r_cnt_n   = 4'd0;
        if (RD_LAT == 0) begin
          r_state_n = R_DATA;
          r_capture = 1'b1;
          rlast_n   = (arlen == 8'd0);
        end else begin
          r_state_n = R_WAIT;
        end
      end
      R_WAIT: if (r_cnt == LAT_LAST) begin
        r_state_n = R_DATA;
        r_capture = 1'b1;
        rlast_n   = (r_len == 8'd0);
      end else begin
        r_cnt_n = r_cnt + 4'd1;
      end
      R_DATA: if (rready) begin
        if (r_beat == r_len) begin
          r_state_n = R_IDLE;
        end else begin
          r_beat_n  = r_beat + 8'd1;
          r_addr_n  = fetch_addr;
          r_capture = 1'b1;
          rlast_n   = (r_beat + 8'd1 == r_len);
        end
      end
      default: r_state_n = R_IDLE;
    endcase
    if (r_capture) begin
      rdata_n = fetch_data;
      rresp_n = fetch_resp;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= R_IDLE;
      r_addr  <= 32'd0;
      r_len   <= 8'd0;
      r_size  <= 3'd0;
      r_burst <= 2'd0;
      r_id    <= 4'd0;
      r_beat  <= 8'd0;
      r_cnt   <= 4'd0;
      rdata   <= 32'd0;
      rresp   <= 2'd0;
      rlast   <= 1'b0;
    end else begin
      r_state <= r_state_n;
      r_addr  <= r_addr_n;
      r_len   <= r_len_n;
      r_size  <= r_size_n;
      r_burst <= r_burst_n;
      r_id    <= r_id_n;
      r_beat  <= r_beat_n;
      r_cnt   <= r_cnt_n;
      rdata   <= rdata_n;
      rresp   <= rresp_n;
      rlast   <= rlast_n;
    end
  end

  // Write response accumulates the worst beat; a wlast that disagrees with the
  // beat count closes the burst with SLVERR.
  always_comb begin
    w_state_n   = w_state;
    w_addr_n    = w_addr;
    w_len_n     = w_len;
    w_size_n    = w_size;
    w_burst_n   = w_burst;
    w_id_n      = w_id;
    w_beat_n    = w_beat;
    w_resp_n    = w_resp;
    wr_en       = 1'b0;
    w_beat_resp = beat_resp(w_addr, ADDR_BASE, SPAN, w_size);
    w_merged    = resp_merge(w_resp, w_beat_resp);
    unique case (w_state)
      W_IDLE: if (awvalid) begin
        w_addr_n  = awaddr;
        w_len_n   = awlen;
        w_size_n  = awsize;
        w_burst_n = awburst;
        w_id_n    = awid;
        w_beat_n  = 8'd0;
        w_resp_n  = RESP_OKAY;
        w_state_n = W_DATA;
      end
      W_DATA: if (wvalid) begin
        wr_en = (w_beat_resp != RESP_DECERR);
        if (w_beat == w_len) begin
          w_state_n = W_RESP;
          if (!wlast) w_merged = resp_merge(w_merged, RESP_SLVERR);
        end else if (wlast) begin
          w_state_n = W_RESP;
          w_merged  = resp_merge(w_merged, RESP_SLVERR);
        end else begin
          w_beat_n = w_beat + 8'd1;
          w_addr_n = beat_advance(w_addr, w_size, w_burst);
        end
        w_resp_n = w_merged;
      end
      W_RESP: if (bready) w_state_n = W_IDLE;
      default: w_state_n = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_state <= W_IDLE;
      w_addr  <= 32'd0;
      w_len   <= 8'd0;
      w_size  <= 3'd0;
      w_burst <= 2'd0;
      w_id    <= 4'd0;
      w_beat  <= 8'd0;
      w_resp  <= RESP_OKAY;
    end else begin
      w_state <= w_state_n;
      w_addr  <= w_addr_n;
      w_len   <= w_len_n;
      w_size  <= w_size_n;
      w_burst <= w_burst_n;
      w_id    <= w_id_n;
      w_beat  <= w_beat_n;
      w_resp  <= w_resp_n;
    end
  end

endmodule

// File: tb/tb_ysyx_20020207_axi_sram_slave.sv
// Directed bench for the AXI SRAM responder; inputs change and outputs are
// sampled on the falling clock edge.
module tb_ysyx_20020207_axi_sram_slave;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [3:0]  awid, wstrb, bid, arid, rid;
  logic [7:0]  awlen, arlen;
  logic [2:0]  awsize, arsize;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic        arvalid, arready, rvalid, rready, rlast;

  int checks = 0;
  int failures = 0;

  logic [31:0] wr_data_q [16];
  logic [3:0]  wr_strb_q [16];
  logic [31:0] rd_data_q [16];
  logic [1:0]  rd_resp_q [16];
  logic        rd_last_q [16];
  logic [3:0]  rd_id_q   [16];
  int          rd_lat_seen;
  logic        rd_stable;

  ysyx_20020207_axi_sram_slave #(
    .ADDR_BASE(32'h8000_0000), .DEPTH_WORDS(4096), .RD_LAT(1)
  ) dut (
    .clk(clk), .rst(rst),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awid(awid),
    .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bresp(bresp), .bid(bid),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid),
    .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
    .rlast(rlast), .rid(rid)
  );

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  task automatic do_write(input logic [31:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input logic [3:0] id,
                          input int wlast_at, output logic [1:0] resp,
                          output logic [3:0] id_o);
    int guard, sent, nbeats;
    @(negedge clk);
    awaddr = addr; awlen = len; awsize = 3'd2; awburst = burst; awid = id; awvalid = 1'b1;
    guard = 0;
    while (!awready && guard < 50) begin @(negedge clk); guard++; end
    checks++;
    if (guard >= 50) begin failures++; $display("[TB] FAIL aw_timeout awready=%b required=1", awready); end
    @(negedge clk);
    awvalid = 1'b0;
    nbeats = (wlast_at < int'(len)) ? wlast_at + 1 : int'(len) + 1;
    sent = 0; guard = 0;
    while (sent < nbeats && guard < 300) begin
      if (wready) begin
        wvalid = 1'b1; wdata = wr_data_q[sent]; wstrb = wr_strb_q[sent];
        wlast = (sent == wlast_at);
        sent++;
      end else begin
        wvalid = 1'b0;
      end
      @(negedge clk); guard++;
    end
    wvalid = 1'b0; wlast = 1'b0;
    bready = 1'b1; guard = 0;
    while (!bvalid && guard < 50) begin @(negedge clk); guard++; end
    checks++;
    if (!bvalid) begin failures++; $display("[TB] FAIL b_timeout bvalid=%b required=1", bvalid); end
    resp = bresp; id_o = bid;
    @(negedge clk);
    bready = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst,
                         input logic [3:0] id, input int stall_beat);
    int guard, got, stall;
    logic [31:0] hold;
    @(negedge clk);
    araddr = addr; arlen = len; arsize = size; arburst = burst; arid = id; arvalid = 1'b1;
    guard = 0;
    while (!arready && guard < 50) begin @(negedge clk); guard++; end
    checks++;
    if (guard >= 50) begin failures++; $display("[TB] FAIL ar_timeout arready=%b required=1", arready); end
    @(negedge clk);
    arvalid = 1'b0;
    got = 0; guard = 0; stall = 0; hold = 32'd0;
    rd_lat_seen = -1; rd_stable = 1'b1;
    while (got <= int'(len) && guard < 300) begin
      if (rvalid) begin
        if (rd_lat_seen < 0) rd_lat_seen = guard + 1;
        if (got == stall_beat && stall < 3) begin
          rready = 1'b0;
          if (stall == 0) hold = rdata;
          else if (rdata !== hold) rd_stable = 1'b0;
          stall++;
        end else begin
          if (stall > 0 && got == stall_beat && rdata !== hold) rd_stable = 1'b0;
          rready = 1'b1;
          rd_data_q[got] = rdata; rd_resp_q[got] = rresp;
          rd_last_q[got] = rlast; rd_id_q[got] = rid;
          got++;
        end
      end else begin
        rready = 1'b0;
      end
      @(negedge clk); guard++;
    end
    rready = 1'b0;
    checks++;
    if (got <= int'(len)) begin failures++; $display("[TB] FAIL r_timeout beats=%0d required=%0d", got, int'(len) + 1); end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({arready, awready, wready, bvalid, rvalid, rlast} !== 6'b110000) begin
      failures++;
      $display("[TB] FAIL reset_handshake got=%b required=110000", {arready, awready, wready, bvalid, rvalid, rlast});
    end
    checks++;
    if ({rdata, rresp, bresp, rid, bid} !== 44'd0) begin
      failures++;
      $display("[TB] FAIL reset_values got=%h required=0", {rdata, rresp, bresp, rid, bid});
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_read();
    logic [1:0] resp; logic [3:0] id_o;
    wr_data_q[0] = 32'hDEAD_BEEF; wr_strb_q[0] = 4'hF;
    do_write(32'h8000_0000, 8'd0, 2'b01, 4'h3, 0, resp, id_o);
    checks++;
    if (resp !== 2'b00 || id_o !== 4'h3) begin failures++; $display("[TB] FAIL single_write_b got=%b/%h required=00/3", resp, id_o); end
    do_read(32'h8000_0000, 8'd0, 3'd2, 2'b01, 4'h5, -1);
    checks++;
    if (rd_lat_seen != 2) begin failures++; $display("[TB] FAIL read_latency got=%0d required=2", rd_lat_seen); end
    checks++;
    if (rd_data_q[0] !== 32'hDEAD_BEEF) begin failures++; $display("[TB] FAIL single_rdata got=%h required=deadbeef", rd_data_q[0]); end
    checks++;
    if ({rd_last_q[0], rd_resp_q[0], rd_id_q[0]} !== {1'b1, 2'b00, 4'h5}) begin
      failures++;
      $display("[TB] FAIL single_rattr got=%b/%b/%h required=1/00/5", rd_last_q[0], rd_resp_q[0], rd_id_q[0]);
    end
  endtask

  task automatic test_incr_burst();
    logic [1:0] resp; logic [3:0] id_o;
    for (int i = 0; i < 4; i++) begin wr_data_q[i] = 32'(i + 1); wr_strb_q[i] = 4'hF; end
    do_write(32'h8000_0010, 8'd3, 2'b01, 4'h1, 3, resp, id_o);
    checks++;
    if (resp !== 2'b00) begin failures++; $display("[TB] FAIL incr_bresp got=%b required=00", resp); end
    do_read(32'h8000_0010, 8'd3, 3'd2, 2'b01, 4'h2, 1);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rd_data_q[i] !== 32'(i + 1) || rd_last_q[i] !== (i == 3)) begin
        failures++;
        $display("[TB] FAIL incr_beat%0d got=%h/%b required=%h/%b", i, rd_data_q[i], rd_last_q[i], 32'(i + 1), (i == 3));
      end
    end
    checks++;
    if (rd_stable !== 1'b1) begin failures++; $display("[TB] FAIL stall_stable got=%b required=1", rd_stable); end
  endtask

  task automatic test_byte_strobe();
    logic [1:0] resp; logic [3:0] id_o;
    wr_data_q[0] = 32'h1122_3344; wr_strb_q[0] = 4'hF;
    do_write(32'h8000_0020, 8'd0, 2'b01, 4'h0, 0, resp, id_o);
    wr_data_q[0] = 32'hAABB_CCDD; wr_strb_q[0] = 4'b0101;
    do_write(32'h8000_0020, 8'd0, 2'b01, 4'h0, 0, resp, id_o);
    do_read(32'h8000_0020, 8'd0, 3'd2, 2'b01, 4'h0, -1);
    checks++;
    if (rd_data_q[0] !== 32'h11BB_33DD) begin failures++; $display("[TB] FAIL byte_strobe got=%h required=11bb33dd", rd_data_q[0]); end
  endtask

  task automatic test_errors();
    logic [1:0] resp; logic [3:0] id_o;
    do_read(32'h0000_1000, 8'd0, 3'd2, 2'b01, 4'h9, -1);
    checks++;
    if (rd_resp_q[0] !== 2'b11 || rd_data_q[0] !== 32'd0) begin
      failures++; $display("[TB] FAIL decerr_read got=%b/%h required=11/0", rd_resp_q[0], rd_data_q[0]);
    end
    do_read(32'h8000_4000, 8'd0, 3'd2, 2'b01, 4'h0, -1);
    checks++;
    if (rd_resp_q[0] !== 2'b11) begin failures++; $display("[TB] FAIL decerr_top got=%b required=11", rd_resp_q[0]); end
    do_read(32'h8000_3FFC, 8'd0, 3'd2, 2'b01, 4'h0, -1);
    checks++;
    if (rd_resp_q[0] !== 2'b00) begin failures++; $display("[TB] FAIL last_word_ok got=%b required=00", rd_resp_q[0]); end
    do_read(32'h8000_0000, 8'd0, 3'd3, 2'b01, 4'h0, -1);
    checks++;
    if (rd_resp_q[0] !== 2'b10) begin failures++; $display("[TB] FAIL size_slverr got=%b required=10", rd_resp_q[0]); end
    wr_data_q[0] = 32'h9; wr_data_q[1] = 32'hA; wr_strb_q[0] = 4'hF; wr_strb_q[1] = 4'hF;
    do_write(32'h8000_0040, 8'd3, 2'b01, 4'h4, 1, resp, id_o);
    checks++;
    if (resp !== 2'b10) begin failures++; $display("[TB] FAIL early_wlast got=%b required=10", resp); end
    do_write(32'h0000_1000, 8'd0, 2'b01, 4'h4, 0, resp, id_o);
    checks++;
    if (resp !== 2'b11) begin failures++; $display("[TB] FAIL decerr_write got=%b required=11", resp); end
    wr_data_q[0] = 32'hA1; wr_data_q[1] = 32'hA2;
    do_write(32'h8000_0030, 8'd1, 2'b01, 4'h6, 5, resp, id_o);
    checks++;
    if (resp !== 2'b10) begin failures++; $display("[TB] FAIL missing_wlast got=%b required=10", resp); end
    do_read(32'h8000_0034, 8'd0, 3'd2, 2'b01, 4'h0, -1);
    checks++;
    if (rd_data_q[0] !== 32'hA2) begin failures++; $display("[TB] FAIL missing_wlast_data got=%h required=a2", rd_data_q[0]); end
  endtask

  task automatic test_fixed_burst();
    logic [1:0] resp; logic [3:0] id_o;
    for (int i = 0; i < 3; i++) begin wr_data_q[i] = 32'(i + 5); wr_strb_q[i] = 4'hF; end
    do_write(32'h8000_0050, 8'd2, 2'b00, 4'h2, 2, resp, id_o);
    checks++;
    if (resp !== 2'b00) begin failures++; $display("[TB] FAIL fixed_bresp got=%b required=00", resp); end
    do_read(32'h8000_0050, 8'd0, 3'd2, 2'b01, 4'h0, -1);
    checks++;
    if (rd_data_q[0] !== 32'd7) begin failures++; $display("[TB] FAIL fixed_final got=%h required=7", rd_data_q[0]); end
  endtask

  task automatic test_concurrency();
    logic [1:0] resp; logic [3:0] id_o;
    wr_data_q[0] = 32'h1111_1111; wr_strb_q[0] = 4'hF;
    do_write(32'h8000_0060, 8'd0, 2'b01, 4'h0, 0, resp, id_o);
    @(negedge clk);
    araddr = 32'h8000_0060; arlen = 8'd0; arsize = 3'd2; arburst = 2'b01; arid = 4'h7; arvalid = 1'b1;
    awaddr = 32'h8000_0060; awlen = 8'd0; awsize = 3'd2; awburst = 2'b01; awid = 4'h8; awvalid = 1'b1;
    checks++;
    if ({arready, awready} !== 2'b11) begin failures++; $display("[TB] FAIL dual_ready got=%b required=11", {arready, awready}); end
    @(negedge clk);
    arvalid = 1'b0; awvalid = 1'b0;
    wdata = 32'h2222_2222; wstrb = 4'hF; wlast = 1'b1; wvalid = 1'b1;
    @(negedge clk);
    wvalid = 1'b0; wlast = 1'b0;
    checks++;
    if (rvalid !== 1'b1 || rdata !== 32'h1111_1111) begin
      failures++; $display("[TB] FAIL same_cycle_old got=%b/%h required=1/11111111", rvalid, rdata);
    end
    checks++;
    if (bvalid !== 1'b1 || bresp !== 2'b00 || bid !== 4'h8) begin
      failures++; $display("[TB] FAIL same_cycle_b got=%b/%b/%h required=1/00/8", bvalid, bresp, bid);
    end
    rready = 1'b1; bready = 1'b1;
    @(negedge clk);
    rready = 1'b0; bready = 1'b0;
    do_read(32'h8000_0060, 8'd0, 3'd2, 2'b01, 4'h0, -1);
    checks++;
    if (rd_data_q[0] !== 32'h2222_2222) begin failures++; $display("[TB] FAIL later_read_new got=%h required=22222222", rd_data_q[0]); end
  endtask

  task automatic test_reset_midburst();
    int guard;
    @(negedge clk);
    araddr = 32'h8000_0010; arlen = 8'd7; arsize = 3'd2; arburst = 2'b01; arid = 4'h2; arvalid = 1'b1;
    @(negedge clk);
    arvalid = 1'b0; rready = 1'b1; guard = 0;
    while (!rvalid && guard < 20) begin @(negedge clk); guard++; end
    checks++;
    if (rvalid !== 1'b1 || rdata !== 32'd1) begin failures++; $display("[TB] FAIL midburst_beat1 got=%b/%h required=1/1", rvalid, rdata); end
    @(negedge clk);
    checks++;
    if (rvalid !== 1'b1 || rdata !== 32'd2) begin failures++; $display("[TB] FAIL midburst_beat2 got=%b/%h required=1/2", rvalid, rdata); end
    rready = 1'b0; rst = 1'b0;
    #1;
    checks++;
    if (rvalid !== 1'b0 || arready !== 1'b1) begin
      failures++; $display("[TB] FAIL async_abort got=%b/%b required=0/1", rvalid, arready);
    end
    @(negedge clk);
    rst = 1'b1;
    do_read(32'h8000_0010, 8'd0, 3'd2, 2'b01, 4'h3, -1);
    checks++;
    if (rd_data_q[0] !== 32'd1 || rd_last_q[0] !== 1'b1 || rd_resp_q[0] !== 2'b00 || rd_id_q[0] !== 4'h3) begin
      failures++;
      $display("[TB] FAIL after_reset got=%h/%b/%b/%h required=1/1/00/3", rd_data_q[0], rd_last_q[0], rd_resp_q[0], rd_id_q[0]);
    end
  endtask

  initial begin
    rst = 1'b0;
    awvalid = 1'b0; awaddr = 32'd0; awid = 4'd0; awlen = 8'd0; awsize = 3'd0; awburst = 2'd0;
    wvalid = 1'b0; wdata = 32'd0; wstrb = 4'd0; wlast = 1'b0; bready = 1'b0;
    arvalid = 1'b0; araddr = 32'd0; arid = 4'd0; arlen = 8'd0; arsize = 3'd0; arburst = 2'd0;
    rready = 1'b0;
    test_reset();
    test_single_read();
    test_incr_burst();
    test_byte_strobe();
    test_errors();
    test_fixed_burst();
    test_concurrency();
    test_reset_midburst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
